alu_issue_stage: RTL and testbench

Decode/issue stage driving the 32-bit integer ALU: accepts a fetched RV32I instruction with its register-file read data, decodes OP, OP-IMM, LUI and AUIPC, and registers `alu_in1`, `alu_in2`, `alu_op_ctrl` and the writeback tag into an ID/EX pipeline register. It sits between fetch/register-file read and the ALU, and produces the 4-bit ALU control code the ALU consumes. Flow control uses valid/ready on both sides, with a flush for branch redirects.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_decode.sv | 96 +++++++++
 rtl/alu_issue_stage.sv | 85 ++++++++
 tb/tb_alu_issue_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU op codes, RV32I opcodes,
// funct7 values and the decoded bundle that travels through the ID/EX register.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      alu_op_e     op;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } alu_bundle_t;

   // Base (funct7 = 0) mapping shared by OP and OP-IMM.
   function automatic alu_op_e op_from_funct3(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode of OP / OP-IMM (and LUI / AUIPC when
// ALU_ISSUE_UPPER_IMM_EN is defined) into an alu_bundle_t.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output alu_bundle_t bundle
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] shamt;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign shamt  = {27'b0, instr[24:20]};

`ifndef ALU_ISSUE_UPPER_IMM_EN
   logic unused_bits;
   assign unused_bits = ^{pc, instr[19:15]};
`endif

   logic        legal;
   alu_op_e     op;
   logic [31:0] in1;
   logic [31:0] in2;

   always_comb begin
      legal = 1'b0;
      op    = ALU_ADD;
      in1   = '0;
      in2   = '0;
      case (opcode)
         OPC_OP: begin
            in1 = rs1_data;
            in2 = rs2_data;
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               op    = op_from_funct3(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal = 1'b1;
               op    = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               legal = 1'b1;
               op    = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            in1   = rs1_data;
            in2   = imm_i;
            legal = 1'b1;
            op    = op_from_funct3(funct3);
            // Shifts carry the shamt only; funct7 must be an exact encoding.
            if (funct3 == 3'b001) begin
               in2   = shamt;
               legal = (funct7 == F7_BASE);
            end else if (funct3 == 3'b101) begin
               in2 = shamt;
               if (funct7 == F7_ALT) begin
                  op = ALU_SRA;
               end else if (funct7 != F7_BASE) begin
                  legal = 1'b0;
               end
            end
         end
`ifdef ALU_ISSUE_UPPER_IMM_EN
         OPC_LUI: begin
            legal = 1'b1;
            in1   = '0;
            in2   = {instr[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            legal = 1'b1;
            in1   = pc;
            in2   = {instr[31:12], 12'b0};
         end
`endif
         default: legal = 1'b0;
      endcase

      bundle.rd      = instr[11:7];
      bundle.illegal = !legal;
      bundle.we      = legal && (instr[11:7] != 5'd0);
      bundle.op      = legal ? op  : ALU_ADD;
      bundle.in1     = legal ? in1 : '0;
      bundle.in2     = legal ? in2 : '0;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: ID/EX register with valid/ready handshake, flush and sticky
// illegal flag. Optional LUI/AUIPC decode under ALU_ISSUE_UPPER_IMM_EN.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_op_ctrl,
   output logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic        illegal,
   output logic        illegal_sticky
);

   alu_bundle_t dec_bundle;
   alu_bundle_t bundle_reg, bundle_next;
   logic        valid_reg, valid_next;
   logic        sticky_reg, sticky_next;
   logic        accept;

   alu_decode u_decode (
      .instr    (instr),
      .pc       (pc),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .bundle   (dec_bundle)
   );

   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];
   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      bundle_next = bundle_reg;
      valid_next  = valid_reg;
      sticky_next = sticky_reg || (valid_reg && out_ready && bundle_reg.illegal);
      // Flush wins over a concurrent accept; stale data fields are harmless.
      if (flush) begin
         valid_next = 1'b0;
      end else if (accept) begin
         valid_next  = 1'b1;
         bundle_next = dec_bundle;
      end else if (out_ready) begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg  <= 1'b0;
         bundle_reg <= '0;
         sticky_reg <= 1'b0;
      end else begin
         valid_reg  <= valid_next;
         bundle_reg <= bundle_next;
         sticky_reg <= sticky_next;
      end
   end

   assign out_valid      = valid_reg;
   assign alu_in1        = bundle_reg.in1;
   assign alu_in2        = bundle_reg.in2;
   assign alu_op_ctrl    = bundle_reg.op;
   assign rd_addr        = bundle_reg.rd;
   assign rd_we          = bundle_reg.we;
   assign illegal        = bundle_reg.illegal;
   assign illegal_sticky = sticky_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected values hand-computed
// from the RV32I encodings. Follows ALU_ISSUE_UPPER_IMM_EN for the AUIPC case.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_op_ctrl;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic        illegal;
   logic        illegal_sticky;

   int checks = 0;
   int errors = 0;

   alu_issue_stage #(.XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .instr          (instr),
      .pc             (pc),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_data       (rs1_data),
      .rs2_data       (rs2_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .alu_in1        (alu_in1),
      .alu_in2        (alu_in2),
      .alu_op_ctrl    (alu_op_ctrl),
      .rd_addr        (rd_addr),
      .rd_we          (rd_we),
      .illegal        (illegal),
      .illegal_sticky (illegal_sticky)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      instr    = i;
      pc       = p;
      rs1_data = a;
      rs2_data = b;
   endtask

   task automatic bundle(input string tag, input logic [31:0] e_in1, input logic [31:0] e_in2,
                         input logic [3:0] e_op, input logic [4:0] e_rd, input logic e_we, input logic e_ill);
      check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, ".in1"}, alu_in1, e_in1);
      check({tag, ".in2"}, alu_in2, e_in2);
      check({tag, ".op"}, {28'b0, alu_op_ctrl}, {28'b0, e_op});
      check({tag, ".rd"}, {27'b0, rd_addr}, {27'b0, e_rd});
      check({tag, ".we"}, {31'b0, rd_we}, {31'b0, e_we});
      check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e_ill});
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
      #12;
      check("reset.out_valid", {31'b0, out_valid}, 32'd0);
      check("reset.in1", alu_in1, 32'd0);
      check("reset.in2", alu_in2, 32'd0);
      check("reset.op", {28'b0, alu_op_ctrl}, 32'd0);
      check("reset.rd_we", {31'b0, rd_we}, 32'd0);
      check("reset.illegal", {31'b0, illegal}, 32'd0);
      check("reset.sticky", {31'b0, illegal_sticky}, 32'd0);
      check("reset.in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      rst = 1'b0;

      // add x3,x1,x2
      drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
      #1;
      check("add.rs1_addr", {27'b0, rs1_addr}, 32'd1);
      check("add.rs2_addr", {27'b0, rs2_addr}, 32'd2);
      tick();
      bundle("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);

      // srai x5,x6,4
      drive(32'h40435293, 32'h0, 32'h80000000, 32'h0);
      tick();
      bundle("srai", 32'h80000000, 32'd4, 4'b0111, 5'd5, 1'b1, 1'b0);

      // same word with funct7 0100001: illegal
      drive(32'h42435293, 32'h0, 32'h80000000, 32'h0);
      tick();
      bundle("srai_bad", 32'd0, 32'd0, 4'b0000, 5'd5, 1'b0, 1'b1);
      check("srai_bad.sticky_pre", {31'b0, illegal_sticky}, 32'd0);
      in_valid = 1'b0;
      tick();
      check("srai_bad.sticky_post", {31'b0, illegal_sticky}, 32'd1);
      check("srai_bad.drain", {31'b0, out_valid}, 32'd0);

      // addi x0,x0,-1
      drive(32'hFFF00013, 32'h0, 32'h0, 32'h0);
      tick();
      bundle("addi_x0", 32'd0, 32'hFFFFFFFF, 4'b0000, 5'd0, 1'b0, 1'b0);

      // auipc x1,0x12345 at pc=0x100
      drive(32'h12345097, 32'h100, 32'h0, 32'h0);
      tick();
`ifdef ALU_ISSUE_UPPER_IMM_EN
      bundle("auipc", 32'h100, 32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0);
`else
      bundle("auipc", 32'd0, 32'd0, 4'b0000, 5'd1, 1'b0, 1'b1);
`endif

      // backpressure: sub x4,x1,x2 held while or x6,x1,x2 waits
      drive(32'h40208233, 32'h0, 32'd10, 32'd3);
      tick();
      bundle("sub", 32'd10, 32'd3, 4'b0001, 5'd4, 1'b1, 1'b0);
      out_ready = 1'b0;
      drive(32'h0020E333, 32'h0, 32'h000000F0, 32'h0000000F);
      #1;
      check("stall.in_ready", {31'b0, in_ready}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("stall.in_ready_hold", {31'b0, in_ready}, 32'd0);
         check("stall.in1_hold", alu_in1, 32'd10);
         check("stall.op_hold", {28'b0, alu_op_ctrl}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("release.in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      bundle("or", 32'h000000F0, 32'h0000000F, 4'b1000, 5'd6, 1'b1, 1'b0);
      drive(32'h0020F3B3, 32'h0, 32'h000000FF, 32'h0000003C);
      tick();
      bundle("and", 32'h000000FF, 32'h0000003C, 4'b1001, 5'd7, 1'b1, 1'b0);
      in_valid = 1'b0;
      tick();
      check("and.drain", {31'b0, out_valid}, 32'd0);

      // flush with held output and a concurrent input
      out_ready = 1'b0;
      drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
      tick();
      check("flush.pre_valid", {31'b0, out_valid}, 32'd1);
      flush = 1'b1;
      drive(32'h40208233, 32'h0, 32'd9, 32'd9);
      tick();
      check("flush.valid", {31'b0, out_valid}, 32'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      check("flush.not_captured", {31'b0, out_valid}, 32'd0);

      // asynchronous reset mid-stream
      drive(32'h40435293, 32'h0, 32'h80000000, 32'h0);
      tick();
      check("rst.pre_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rst.out_valid", {31'b0, out_valid}, 32'd0);
      check("rst.in2", alu_in2, 32'd0);
      check("rst.in1", alu_in1, 32'd0);
      check("rst.op", {28'b0, alu_op_ctrl}, 32'd0);
      check("rst.rd", {27'b0, rd_addr}, 32'd0);
      check("rst.rd_we", {31'b0, rd_we}, 32'd0);
      check("rst.sticky", {31'b0, illegal_sticky}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
